// File: rtl/scanner_buffer_unit_if.sv
// Station/scanner bus bundle: command, sample input, transfer handshake and status.
interface scanner_buffer_unit_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LVL_W  = 4
);
    logic [1:0]        cmd;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              xfer_ready;
    logic              xfer_valid;
    logic [DATA_W-1:0] xfer_data;
    logic              ready_xfer;
    logic              near_full;
    logic              done;
    logic              overflow;
    logic [LVL_W-1:0]  level;
    logic [2:0]        state;

    // Station/sensor side: drives commands and samples, consumes buffered data.
    modport master (
        output cmd, sample_in, sample_valid, xfer_ready,
        input  xfer_valid, xfer_data, ready_xfer, near_full, done, overflow, level, state
    );

    // Scanner buffer side.
    modport slave (
        input  cmd, sample_in, sample_valid, xfer_ready,
        output xfer_valid, xfer_data, ready_xfer, near_full, done, overflow, level, state
    );
endinterface

// File: rtl/scanner_buffer_unit.sv
// Scanner-side circular sample buffer: collects samples, reports fill status,
// streams them to the station over valid/ready or discards them on flush.
module scanner_buffer_unit #(
    parameter int unsigned DEPTH     = 10,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned READY_LVL = 5,
    parameter int unsigned NEAR_LVL  = 8,
    parameter int unsigned LVL_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    scanner_buffer_unit_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] ST_LOW_POWER = 3'd0;
    localparam logic [2:0] ST_COLLECT   = 3'd1;
    localparam logic [2:0] ST_IDLE      = 3'd2;
    localparam logic [2:0] ST_TRANSFER  = 3'd3;
    localparam logic [2:0] ST_FLUSH     = 3'd4;

    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_XFER  = 2'b10;
    localparam logic [1:0] CMD_FLUSH = 2'b11;

    logic [2:0]        state_q,    state_d;
    logic [LVL_W-1:0]  level_q,    level_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic              done_q,     done_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] buf_q [DEPTH];

    logic wr_en;
    logic xfer_valid;
    logic accept;
    logic do_flush;

    // Pointer advance with an exact wrap at DEPTH (no power-of-2 assumption).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign xfer_valid = (state_q == ST_TRANSFER) && (level_q != '0);
    assign accept     = xfer_valid && bus.xfer_ready;
    assign do_flush   = (bus.cmd == CMD_FLUSH) &&
                        ((state_q == ST_COLLECT) || (state_q == ST_IDLE) ||
                         (state_q == ST_TRANSFER));

    // Next-state, pointer, level and status-flag computation.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;

        if (state_q == ST_IDLE && bus.sample_valid) begin
            overflow_d = 1'b1;
        end

        // Flush takes priority over any same-cycle write or accept.
        if (do_flush) begin
            state_d  = ST_FLUSH;
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            case (state_q)
                ST_LOW_POWER: begin
                    if (bus.cmd == CMD_START) begin
                        state_d    = ST_COLLECT;
                        overflow_d = 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (bus.sample_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        level_d  = level_q + 1'b1;
                        if (level_q == LVL_W'(DEPTH - 1)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    // An eligible transfer request wins over the fill-to-idle move.
                    if (bus.cmd == CMD_XFER && level_q >= LVL_W'(READY_LVL)) begin
                        state_d = ST_TRANSFER;
                    end
                end
                ST_IDLE: begin
                    if (bus.cmd == CMD_XFER) begin
                        state_d = ST_TRANSFER;
                    end
                end
                ST_TRANSFER: begin
                    if (accept) begin
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                        level_d  = level_q - 1'b1;
                        if (level_q == LVL_W'(1)) begin
                            state_d = ST_LOW_POWER;
                        end
                    end else if (level_q == '0) begin
                        state_d = ST_LOW_POWER;
                    end
                end
                ST_FLUSH: begin
                    state_d = ST_LOW_POWER;
                end
                default: begin
                    state_d = ST_LOW_POWER;
                end
            endcase
        end
    end

    // Control registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOW_POWER;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    // Sample storage; contents are only observable through the read pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_ptr_q] <= bus.sample_in;
        end
    end

    assign bus.xfer_valid = xfer_valid;
    assign bus.xfer_data  = xfer_valid ? buf_q[rd_ptr_q] : '0;
    assign bus.ready_xfer = (level_q >= LVL_W'(READY_LVL));
    assign bus.near_full  = (level_q >= LVL_W'(NEAR_LVL));
    assign bus.done       = done_q;
    assign bus.overflow   = overflow_q;
    assign bus.level      = level_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_scanner_buffer_unit.sv
// Self-checking bench for scanner_buffer_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_scanner_buffer_unit;
    localparam int DEPTH = 10;
    localparam int RLVL  = 5;
    localparam int NLVL  = 8;

    localparam int M_LP   = 0;
    localparam int M_COL  = 1;
    localparam int M_IDLE = 2;
    localparam int M_XFER = 3;
    localparam int M_FL   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    scanner_buffer_unit_if #(.DATA_W(8), .LVL_W(4)) bus ();

    scanner_buffer_unit #(
        .DEPTH(DEPTH), .DATA_W(8), .READY_LVL(RLVL), .NEAR_LVL(NLVL), .LVL_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: buffer contents as a FIFO queue plus mode and flags.
    logic [7:0] mq[$];
    int         m_state;
    bit         m_ovf;
    bit         m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit v;
        v = (m_state == M_XFER) && (mq.size() > 0);
        chk("state",      32'(bus.state),      32'(m_state));
        chk("level",      32'(bus.level),      32'(mq.size()));
        chk("ready_xfer", 32'(bus.ready_xfer), 32'(mq.size() >= RLVL));
        chk("near_full",  32'(bus.near_full),  32'(mq.size() >= NLVL));
        chk("done",       32'(bus.done),       32'(m_done));
        chk("overflow",   32'(bus.overflow),   32'(m_ovf));
        chk("xfer_valid", 32'(bus.xfer_valid), 32'(v));
        chk("xfer_data",  32'(bus.xfer_data),  v ? 32'(mq[0]) : 32'd0);
    endtask

    task automatic model_update(input logic [1:0] c, input logic v, input logic [7:0] d,
                                input logic r);
        bit go;
        m_done = 1'b0;
        case (m_state)
            M_LP: if (c == 2'b01) begin m_state = M_COL; m_ovf = 1'b0; end
            M_COL: begin
                if (c == 2'b11) begin
                    mq.delete(); m_state = M_FL;
                end else begin
                    go = (c == 2'b10) && (mq.size() >= RLVL);
                    if (v) begin
                        mq.push_back(d);
                        if (mq.size() == DEPTH) begin m_done = 1'b1; m_state = M_IDLE; end
                    end
                    if (go) m_state = M_XFER;
                end
            end
            M_IDLE: begin
                if (v) m_ovf = 1'b1;
                if (c == 2'b11) begin mq.delete(); m_state = M_FL; end
                else if (c == 2'b10) m_state = M_XFER;
            end
            M_XFER: begin
                if (c == 2'b11) begin
                    mq.delete(); m_state = M_FL;
                end else if (r && mq.size() > 0) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) m_state = M_LP;
                end
            end
            default: m_state = M_LP;
        endcase
    endtask

    task automatic step(input logic [1:0] c, input logic v, input logic [7:0] d, input logic r);
        bus.cmd = c; bus.sample_valid = v; bus.sample_in = d; bus.xfer_ready = r;
        @(posedge clk);
        model_update(c, v, d, r);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        mq.delete(); m_state = M_LP; m_ovf = 1'b0; m_done = 1'b0;
        #1;
        rst = 1'b0;
        check_all();
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) step(2'b00, 1'b1, base + 8'(i), 1'b0);
    endtask

    task automatic drain(output int emitted);
        emitted = 0;
        for (int k = 0; k < 30 && bus.state == 3'd3; k++) begin
            if (bus.xfer_valid) emitted++;
            step(2'b00, 1'b0, 8'h00, 1'b1);
        end
    endtask

    initial begin
        int n;
        logic [1:0] c;
        int rc;
        bus.cmd = 2'b00; bus.sample_valid = 1'b0; bus.sample_in = 8'h00; bus.xfer_ready = 1'b0;
        mq.delete(); m_state = M_LP; m_ovf = 1'b0; m_done = 1'b0;
        @(posedge clk); #1;

        // Reset and full collection of 0x11..0x1A.
        do_reset();
        chk("rst_data", 32'(bus.xfer_data), 32'd0);
        step(2'b01, 1'b0, 8'h00, 1'b0);
        fill(10, 8'h11);
        chk("full_level", 32'(bus.level), 32'd10);
        chk("full_state", 32'(bus.state), 32'd2);

        // Full transfer with xfer_ready held high.
        step(2'b10, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("seq_data", 32'(bus.xfer_data), 32'(8'h11 + 8'(i)));
            step(2'b00, 1'b0, 8'h00, 1'b1);
        end
        chk("xfer_end_state", 32'(bus.state), 32'd0);
        chk("xfer_end_valid", 32'(bus.xfer_valid), 32'd0);

        // Stall: ready 1,0,0,1 holds 0x12.
        step(2'b01, 1'b0, 8'h00, 1'b0);
        fill(10, 8'h11);
        step(2'b10, 1'b0, 8'h00, 1'b0);
        step(2'b00, 1'b0, 8'h00, 1'b1);
        step(2'b00, 1'b0, 8'h00, 1'b0);
        chk("stall_hold1", 32'(bus.xfer_data), 32'h12);
        step(2'b00, 1'b0, 8'h00, 1'b0);
        chk("stall_hold2", 32'(bus.xfer_data), 32'h12);
        step(2'b00, 1'b0, 8'h00, 1'b1);
        chk("stall_next", 32'(bus.xfer_data), 32'h13);
        drain(n);
        chk("stall_emitted", 32'(n), 32'd8);
        chk("stall_end_state", 32'(bus.state), 32'd0);

        // Early transfer request ignored, then a 6-sample transfer.
        step(2'b01, 1'b0, 8'h00, 1'b0);
        fill(3, 8'h30);
        step(2'b10, 1'b0, 8'h00, 1'b0);
        chk("early_xfer_ignored", 32'(bus.state), 32'd1);
        fill(3, 8'h33);
        step(2'b10, 1'b0, 8'h00, 1'b0);
        chk("xfer6_state", 32'(bus.state), 32'd3);
        drain(n);
        chk("xfer6_emitted", 32'(n), 32'd6);

        // Pointers now sit mid-buffer: a full cycle exercises the wrap.
        step(2'b01, 1'b0, 8'h00, 1'b0);
        fill(10, 8'h50);
        step(2'b10, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("wrap_data", 32'(bus.xfer_data), 32'(8'h50 + 8'(i)));
            step(2'b00, 1'b0, 8'h00, 1'b1);
        end

        // Overflow in IDLE, flush, and clear on start.
        step(2'b01, 1'b0, 8'h00, 1'b0);
        fill(10, 8'h60);
        step(2'b00, 1'b1, 8'hAA, 1'b0);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("ovf_level", 32'(bus.level), 32'd10);
        step(2'b11, 1'b0, 8'h00, 1'b0);
        chk("flush_level", 32'(bus.level), 32'd0);
        chk("flush_state", 32'(bus.state), 32'd4);
        step(2'b00, 1'b0, 8'h00, 1'b0);
        chk("flush_exit", 32'(bus.state), 32'd0);
        step(2'b01, 1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(bus.overflow), 32'd0);

        // Partial transfer, flush mid-transfer, refill and compare order.
        fill(10, 8'h20);
        step(2'b10, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) step(2'b00, 1'b0, 8'h00, 1'b1);
        step(2'b11, 1'b1, 8'hEE, 1'b1);
        step(2'b00, 1'b0, 8'h00, 1'b0);
        step(2'b01, 1'b0, 8'h00, 1'b0);
        fill(10, 8'h40);
        step(2'b10, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("refill_data", 32'(bus.xfer_data), 32'(8'h40 + 8'(i)));
            step(2'b00, 1'b0, 8'h00, 1'b1);
        end

        // Reset mid-transfer at level 4.
        step(2'b01, 1'b0, 8'h00, 1'b0);
        fill(10, 8'h70);
        step(2'b10, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) step(2'b00, 1'b0, 8'h00, 1'b1);
        chk("pre_rst_level", 32'(bus.level), 32'd4);
        bus.xfer_ready = 1'b1;
        do_reset();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_valid", 32'(bus.xfer_valid), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                rc = int'($urandom_range(0, 39));
                c = (rc < 28) ? 2'b00 : (rc < 33) ? 2'b01 : (rc < 38) ? 2'b10 : 2'b11;
                step(c, 1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 3) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
